// File: rtl/data_mem_write_buffer.sv
// data_mem_write_buffer
//   Posted-store write buffer between the Memory stage and a multi-cycle data
//   memory with a req/ack handshake. Stores are queued and drained to memory
//   in the background. Loads are handled in one of two ways:
//     - forwarded from the youngest matching buffered store, or
//     - read from memory once the buffer is empty, with StallM held high
//       until the data is available.
//
// Ports
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-low reset
//   MemWriteM    store in Memory stage
//   MemReadM     load in Memory stage (never together with MemWriteM)
//   ALU_ResultM  access address (word aligned; bits [1:0] ignored in the compare)
//   WriteDataM   store data
//   StallM       freeze F/D/E/M; inputs are held stable while high
//   ReadDataM    load data, valid when MemReadM && !StallM
//   mem_req      memory request, held until mem_ack
//   mem_we       1 = write, 0 = read
//   mem_addr     memory address
//   mem_wdata    memory write data
//   mem_ack      transaction complete (only meaningful while mem_req)
//   mem_rdata    read data, valid with mem_ack on a read
//
// FSM states
//   state   | meaning
//   S_IDLE  | no bus transaction; request is low for at least this one cycle
//   S_WRITE | draining the FIFO head to memory
//   S_READ  | load miss being read from memory (buffer already empty)

module data_mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [ADDR_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              rd_done_q;
  logic [DATA_W-1:0] rdata_q;

  logic              full, empty;
  logic              enq, deq, rd_ack;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign enq    = MemWriteM && !full;
  assign deq    = (state_q == S_WRITE) && mem_ack;
  assign rd_ack = (state_q == S_READ) && mem_ack;

  // Walk entries oldest to youngest so the last match is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (addr_q[idx][ADDR_W-1:2] == ALU_ResultM[ADDR_W-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // rd_done masks the miss for the single cycle the pipeline advances past
  // a completed memory read.
  assign StallM    = (MemWriteM && full) || (MemReadM && !hit && !rd_done_q);
  assign ReadDataM = hit ? fwd_data : rdata_q;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        // Draining first keeps every read behind all older stores.
        if (!empty) begin
          state_d = S_WRITE;
        end else if (MemReadM && !hit && !rd_done_q) begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[rd_ptr_q];
        mem_wdata = data_q[rd_ptr_q];
        if (mem_ack) state_d = S_IDLE;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = ALU_ResultM;
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_done_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_done_q <= rd_ack;
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (rd_ack) rdata_q <= mem_rdata;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= ALU_ResultM;
      data_q[wr_ptr_q] <= WriteDataM;
    end
  end

endmodule

// File: tb/tb_data_mem_write_buffer.sv
module tb_data_mem_write_buffer;

  logic        clk;
  logic        rst;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  data_mem_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALU_ResultM(ALU_ResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t log_q[$];
  bus_t exp_q[$];
  int   log_rd   = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   gap_viol = 0;
  logic prev_ack = 1'b0;

  // memory responder controls
  int          auto_ack  = 0;
  int          ack_delay = 0;
  int          grants    = 0;
  int          used      = 0;
  int          wcnt      = 0;
  logic [31:0] rdata_val = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory model: ack after ack_delay cycles of request, one cycle wide.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ack || !rst || !mem_req) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (auto_ack != 0 || grants > used) begin
        if (wcnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata_val;
          wcnt      = 0;
          if (auto_ack == 0) used = used + 1;
        end else begin
          wcnt = wcnt + 1;
        end
      end
    end
  end

  // Bus monitor: logs completed transactions and back-to-back requests.
  always @(posedge clk) begin
    if (rst) begin
      if (mem_req && mem_ack) log_q.push_back('{mem_we, mem_addr, mem_wdata});
      if (prev_ack && mem_req) gap_viol <= gap_viol + 1;
      prev_ack <= mem_req && mem_ack;
    end else begin
      prev_ack <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int n;
    MemWriteM   = 1'b1;
    MemReadM    = 1'b0;
    ALU_ResultM = a;
    WriteDataM  = d;
    #1;
    n = 0;
    while (StallM && n < 200) begin
      cyc();
      n++;
    end
    chk("store_stall_timeout", n < 200, 1);
    cyc();
    MemWriteM = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b1, a, d});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((dut.count_q != 0 || mem_req) && n < 500) begin
      cyc();
      n++;
    end
    chk("drain_timeout", n < 500, 1);
  endtask

  task automatic check_bus(input string tag);
    bus_t e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (log_rd < log_q.size()) begin
        a = log_q[log_rd];
        log_rd++;
        chk({tag, "_we"}, a.we, e.we);
        chk({tag, "_addr"}, a.addr, e.addr);
        if (e.we) chk({tag, "_wdata"}, a.data, e.data);
      end else begin
        chk({tag, "_missing_txn"}, 0, 1);
      end
    end
    chk({tag, "_extra_txn"}, log_q.size() - log_rd, 0);
  endtask

  initial begin
    int n;
    rst         = 1'b0;
    MemWriteM   = 1'b0;
    MemReadM    = 1'b0;
    ALU_ResultM = 32'h0;
    WriteDataM  = 32'h0;

    // reset state
    cyc();
    cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_count", dut.count_q, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    cyc();

    // 1: reset asserted mid-WRITE with no ack
    auto_ack = 0;
    store(32'h10, 32'h11);
    n = 0;
    while (!mem_req && n < 20) begin
      cyc();
      n++;
    end
    chk("t1_req_seen", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("t1_req_dropped", mem_req, 0);
    chk("t1_count", dut.count_q, 0);
    chk("t1_stall", StallM, 0);
    chk("t1_rdata", ReadDataM, 0);
    cyc();
    rst = 1'b1;
    cyc();
    check_bus("t1");

    // 2: fill to DEPTH, fifth store stalls until one dequeue
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      MemWriteM   = 1'b1;
      ALU_ResultM = 32'h400 + 32'(i * 4);
      WriteDataM  = 32'hA0 + 32'(i);
      #1;
      chk("t2_no_stall", StallM, 0);
      cyc();
      push_wr(32'h400 + 32'(i * 4), 32'hA0 + 32'(i));
    end
    ALU_ResultM = 32'h410;
    WriteDataM  = 32'hA4;
    #1;
    chk("t2_full_stall", StallM, 1);
    chk("t2_count_full", dut.count_q, 4);
    grants = grants + 1;
    n = 0;
    while (!mem_ack && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t2_ack_seen", mem_ack, 1);
    chk("t2_stall_in_ack_cycle", StallM, 1);
    cyc();
    chk("t2_stall_released", StallM, 0);
    chk("t2_count_after_deq", dut.count_q, 3);
    cyc();
    MemWriteM = 1'b0;
    chk("t2_count_after_enq", dut.count_q, 4);
    push_wr(32'h410, 32'hA4);
    auto_ack = 1;
    drain();
    check_bus("t2");

    // 3: store then load same address -> forwarded, no bus read
    store(32'h100, 32'hDEADBEEF);
    push_wr(32'h100, 32'hDEADBEEF);
    MemReadM    = 1'b1;
    ALU_ResultM = 32'h100;
    #1;
    chk("t3_fwd_data", ReadDataM, 32'hDEADBEEF);
    chk("t3_stall", StallM, 0);
    cyc();
    MemReadM = 1'b0;
    drain();
    check_bus("t3");

    // 4: buffered stores drain before a load miss is read
    ack_delay = 1;
    rdata_val = 32'h12345678;
    store(32'h300, 32'hAAAA0300);
    push_wr(32'h300, 32'hAAAA0300);
    store(32'h304, 32'hBBBB0304);
    push_wr(32'h304, 32'hBBBB0304);
    exp_q.push_back('{1'b0, 32'h200, 32'h0});
    MemReadM    = 1'b1;
    ALU_ResultM = 32'h200;
    #1;
    chk("t4_miss_stall", StallM, 1);
    n = 0;
    while (StallM && n < 200) begin
      cyc();
      n++;
    end
    chk("t4_stall_timeout", n < 200, 1);
    chk("t4_rdata", ReadDataM, 32'h12345678);
    chk("t4_read_done_before_release", log_q.size() - log_rd, 3);
    cyc();
    MemReadM = 1'b0;
    check_bus("t4");

    // 5: two stores same word -> youngest forwarded, low address bits ignored
    auto_ack  = 0;
    ack_delay = 0;
    store(32'h40, 32'h1);
    push_wr(32'h40, 32'h1);
    store(32'h40, 32'h2);
    push_wr(32'h40, 32'h2);
    MemReadM    = 1'b1;
    ALU_ResultM = 32'h40;
    #1;
    chk("t5_youngest", ReadDataM, 32'h2);
    chk("t5_stall", StallM, 0);
    ALU_ResultM = 32'h43;
    #1;
    chk("t5_lowbits_ignored", ReadDataM, 32'h2);
    cyc();
    MemReadM = 1'b0;
    auto_ack = 1;
    drain();
    check_bus("t5");

    // 6: ten stores with 2-cycle memory wait, pointer wrap, ordering
    ack_delay = 2;
    for (int i = 0; i < 10; i++) begin
      store(32'(i * 4), 32'hC0DE0000 + 32'(i));
      push_wr(32'(i * 4), 32'hC0DE0000 + 32'(i));
    end
    drain();
    check_bus("t6");
    chk("req_gap", gap_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
